// File: rtl/decision_arbiter_pkg.sv
// Shared definitions for the round-decision unit: "no event" code, FSM state encoding
// and a constant-evaluable clog2 used to size index and timer fields.
package decision_arbiter_pkg;

  localparam int unsigned CODE_NONE = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  // Minimum width able to index 'value' items; never returns 0 so fields stay legal.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/decision_arbiter_rr_priority_pick.sv
// Round-robin priority picker: returns the first requesting channel at or after ptr_i,
// wrapping around, plus a flag saying whether any channel requested.
module rr_priority_pick
  import decision_arbiter_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned IDX_W = clog2_f(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             any_o
);

  // Scan from farthest to nearest offset so the nearest requester is the last one written.
  always_comb begin
    int             idx;
    logic [IDX_W-1:0] sel;
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = int'(N_CH) - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      idx = (idx >= int'(N_CH)) ? (idx - int'(N_CH)) : idx;
      sel = IDX_W'(idx);
      grant_o = req_i[sel] ? sel  : grant_o;
      any_o   = req_i[sel] ? 1'b1 : any_o;
    end
  end

endmodule

// File: rtl/decision_arbiter.sv
// Round-decision unit: collects per-channel events, picks a winner (correct beats out/wrong,
// round-robin among channels) and holds it until acknowledged. DECISION_SCORE_EN adds scores.
module decision_arbiter
  import decision_arbiter_pkg::*;
#(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CODE_W  = 2,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned SCORE_W = 8
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Start,
  input  logic [N_CH-1:0]            Guess_valid,
  input  logic [N_CH*CODE_W-1:0]     Correct_guess,
  input  logic [N_CH*CODE_W-1:0]     Out_wr,
  input  logic                       Result_ack,
  output logic [CODE_W-1:0]          Result,
  output logic [clog2_f(N_CH)-1:0]   Winner,
  output logic                       Result_valid,
  output logic                       Timeout,
  output logic                       Busy,
  output logic [N_CH*SCORE_W-1:0]    Score
);

  localparam int unsigned WIN_W = clog2_f(N_CH);
  localparam int unsigned TMR_W = clog2_f(TIMEOUT);

  state_e             state_q, state_d;
  logic [CODE_W-1:0]  result_q, result_d;
  logic [WIN_W-1:0]   winner_q, winner_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic [WIN_W-1:0]   ptr_q, ptr_d;
  logic [TMR_W-1:0]   timer_q, timer_d;

  logic [N_CH-1:0]    corr_req_s, out_req_s;
  logic [WIN_W-1:0]   corr_idx_s, out_idx_s;
  logic               corr_any_s, out_any_s;
  logic [CODE_W-1:0]  corr_code_s, out_code_s;

  function automatic logic [WIN_W-1:0] ptr_after(input logic [WIN_W-1:0] w);
    return (int'(w) == int'(N_CH) - 1) ? '0 : (w + WIN_W'(1));
  endfunction

  // A channel with a non-zero correct code also counts as correct even if it reports out/wrong.
  always_comb begin
    corr_req_s = '0;
    out_req_s  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      corr_req_s[i] = Guess_valid[i] & (|Correct_guess[i*CODE_W +: CODE_W]);
      out_req_s[i]  = Guess_valid[i] & (|Out_wr[i*CODE_W +: CODE_W]);
    end
  end

  rr_priority_pick #(.N_CH(N_CH), .IDX_W(WIN_W)) u_pick_corr (
    .req_i   (corr_req_s),
    .ptr_i   (ptr_q),
    .grant_o (corr_idx_s),
    .any_o   (corr_any_s)
  );

  rr_priority_pick #(.N_CH(N_CH), .IDX_W(WIN_W)) u_pick_out (
    .req_i   (out_req_s),
    .ptr_i   (ptr_q),
    .grant_o (out_idx_s),
    .any_o   (out_any_s)
  );

  // Fetch the code belonging to each picked channel.
  always_comb begin
    corr_code_s = '0;
    out_code_s  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      corr_code_s = (corr_idx_s == WIN_W'(i)) ? Correct_guess[i*CODE_W +: CODE_W] : corr_code_s;
      out_code_s  = (out_idx_s  == WIN_W'(i)) ? Out_wr[i*CODE_W +: CODE_W]        : out_code_s;
    end
  end

  // Round FSM, timer, pointer and result next-state.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    winner_d  = winner_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    busy_d    = busy_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_COLLECT;
          timer_d = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (corr_any_s) begin
          result_d  = corr_code_s;
          winner_d  = corr_idx_s;
          ptr_d     = ptr_after(corr_idx_s);
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (out_any_s) begin
          result_d  = out_code_s;
          winner_d  = out_idx_s;
          ptr_d     = ptr_after(out_idx_s);
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          result_d  = CODE_W'(CODE_NONE);
          winner_d  = '0;
          valid_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_DONE: begin
        if (Result_ack) begin
          state_d   = ST_IDLE;
          valid_d   = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      winner_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      ptr_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      winner_q  <= winner_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
    end
  end

  assign Result       = result_q;
  assign Winner       = winner_q;
  assign Result_valid = valid_q;
  assign Timeout      = timeout_q;
  assign Busy         = busy_q;

`ifdef DECISION_SCORE_EN
  logic [N_CH*SCORE_W-1:0] score_q;
  logic                    score_hit_s;

  assign score_hit_s = (state_q == ST_COLLECT) && corr_any_s;

  // Saturating per-channel counters, bumped only on correct-guess wins.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        if (score_hit_s && (corr_idx_s == WIN_W'(i)) &&
            (score_q[i*SCORE_W +: SCORE_W] != {SCORE_W{1'b1}})) begin
          score_q[i*SCORE_W +: SCORE_W] <= score_q[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
        end else begin
          score_q[i*SCORE_W +: SCORE_W] <= score_q[i*SCORE_W +: SCORE_W];
        end
      end
    end
  end

  assign Score = score_q;
`else
  assign Score = '0;
`endif

endmodule
